// File: rtl/lsu_sequencer.sv
// Load/store sequencer: aligns CPU memory requests onto a word-wide bus,
// stalls the pipeline while the access is outstanding and reports completion/errors.
module lsu_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  length,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic [1:0]  err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] E_NONE     = 2'b00;
  localparam logic [1:0] E_MISALIGN = 2'b01;
  localparam logic [1:0] E_TIMEOUT  = 2'b10;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  len_q;
  logic        uns_q;
  logic        we_q;
  logic [7:0]  cnt;
  logic [1:0]  err_q;

  logic        req;
  logic        aligned;
  logic        busy;
  logic [3:0]  strb;
  logic [31:0] ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req  = mem_rd | mem_wr;
  assign busy = (state == S_BUSY);

  always_comb begin
    aligned = 1'b1;
    case (length)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    strb      = 4'b1111;
    bus_wdata = wdata_q;
    case (len_q)
      2'b00: begin
        strb      = 4'b0001 << addr_q[1:0];
        bus_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strb      = 4'b0011 << {addr_q[1], 1'b0};
        bus_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        strb      = 4'b1111;
        bus_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (addr_q[1:0])
      2'b00: ld_byte = bus_rdata[7:0];
      2'b01: ld_byte = bus_rdata[15:8];
      2'b10: ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (len_q)
      2'b00:   ld_val = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
      2'b01:   ld_val = {{16{ld_half[15] & ~uns_q}}, ld_half};
      default: ld_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt     <= '0;
      err_q   <= E_NONE;
      rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (req) begin
            if (aligned) begin
              addr_q  <= addr;
              wdata_q <= wdata;
              len_q   <= length;
              uns_q   <= uns;
              we_q    <= mem_wr;
              state   <= S_BUSY;
            end else begin
              err_q <= E_MISALIGN;
              state <= S_ERR;
            end
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            if (!we_q) rdata <= ld_val;
            err_q <= E_NONE;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            err_q <= E_TIMEOUT;
            state <= S_ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus_req   = busy;
  assign bus_we    = busy & we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wstrb = (busy && we_q) ? strb : 4'b0000;
  // The IDLE term lets the pipeline freeze in the same cycle the request appears.
  assign stall     = rst_n & (busy | ((state == S_IDLE) & req));
  assign done      = (state == S_DONE) | (state == S_ERR);
  assign err       = done ? err_q : E_NONE;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Randomized self-checking bench for lsu_sequencer against a transaction-level model.
module tb_lsu_sequencer;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd, mem_wr, uns, bus_ack;
  logic [1:0]  length;
  logic [31:0] addr, wdata, bus_rdata;
  logic        bus_req, bus_we, stall, done;
  logic [31:0] bus_addr, bus_wdata, rdata;
  logic [3:0]  bus_wstrb;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = '0;

  lsu_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .length(length), .uns(uns), .addr(addr), .wdata(wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .stall(stall), .rdata(rdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One request held until its done pulse; d = BUSY cycle index of the ack (d >= TO: never).
  task automatic txn(input logic rd, input logic wr, input logic [1:0] len, input logic un,
                     input logic [31:0] a, input logic [31:0] wd, input int unsigned d,
                     input logic [31:0] rw);
    logic        ok;
    logic [3:0]  es;
    logic [31:0] ewd, eld, sh;
    logic [1:0]  eerr;
    int unsigned nbusy, done_at;
    logic        in_busy;
    ok = (len == 2'b00) || (len == 2'b01 ? (a[0] == 1'b0) : (a[1:0] == 2'b00));
    case (len)
      2'b00: begin es = 4'(1 << a[1:0]); ewd = {24'd0, wd[7:0]} * 32'h0101_0101; end
      2'b01: begin es = 4'(3 << (a[1:0] & 2'b10)); ewd = {16'd0, wd[15:0]} * 32'h0001_0001; end
      default: begin es = 4'hF; ewd = wd; end
    endcase
    if (!wr) es = 4'h0;
    if (len == 2'b00) begin
      sh  = rw >> (8 * a[1:0]);
      eld = sh & 32'hFF;
      if (!un && eld >= 32'd128) eld = eld - 32'd256;
    end else if (len == 2'b01) begin
      sh  = rw >> (16 * a[1]);
      eld = sh & 32'hFFFF;
      if (!un && eld >= 32'd32768) eld = eld - 32'd65536;
    end else eld = rw;
    if (!ok) begin nbusy = 0; eerr = 2'b01; end
    else if (d < TO) begin nbusy = d + 1; eerr = 2'b00; end
    else begin nbusy = TO; eerr = 2'b10; end
    done_at = nbusy + 1;

    for (int unsigned k = 0; k <= done_at; k++) begin
      @(posedge clk); #1;
      in_busy = (k >= 1) && (k <= nbusy);
      if (k == 0) begin
        mem_rd = rd; mem_wr = wr; length = len; uns = un; addr = a; wdata = wd;
      end
      if (in_busy) begin
        bus_ack   = (k - 1 == d);
        bus_rdata = (k - 1 == d) ? rw : $urandom;
      end else begin
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      @(negedge clk);
      check("stall", stall, (k == 0) || in_busy);
      check("bus_req", bus_req, in_busy);
      check("done", done, k == done_at);
      if (in_busy) begin
        check("bus_we", bus_we, wr);
        check("bus_addr", bus_addr, {a[31:2], 2'b00});
        check("bus_wstrb", bus_wstrb, es);
        if (wr) check("bus_wdata", bus_wdata, ewd);
      end
      if (k == done_at) begin
        check("err", err, eerr);
        if (!wr && eerr == 2'b00) model_rdata = eld;
        check("rdata", rdata, model_rdata);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; length = '0; uns = 1'b0;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    #2;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_wstrb", bus_wstrb, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk); rst_n = 1'b1;

    // LB sign-extended from lane 3, ack on 2nd BUSY cycle
    txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1, 32'h80FF_0000);
    // SH upper half
    txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, 0, $urandom);
    // LW misaligned
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 0, 32'h0);
    // LHU timeout
    txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, TO, 32'h0);
    // rd+wr together is a store
    txn(1'b1, 1'b1, 2'b00, 1'b0, 32'h5, 32'h1234_5678, 0, $urandom);

    // reset in the middle of a BUSY access
    @(posedge clk); #1;
    mem_rd = 1'b1; mem_wr = 1'b0; length = 2'b10; addr = 32'h200; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_bus_req", bus_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_bus_req", bus_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_done", done, 0);
    model_rdata = '0;
    check("mid_rst_rdata", rdata, model_rdata);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rd = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_req", bus_req, 0);
      check("late_ack_done", done, 0);
      check("late_ack_rdata", rdata, model_rdata);
    end
    bus_ack = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic        r, w;
      int unsigned d;
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      d = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 4);
      txn(r, w, 2'($urandom), 1'($urandom), $urandom, $urandom, d, $urandom);
    end

    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
    @(negedge clk);
    check("final_idle_stall", stall, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
